// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS fetch stage: word width,
// instruction field positions, fetch FSM states and next-PC helpers.
package mips_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned TARGET_W = 26;
    localparam int unsigned IMM_W    = 16;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    // Sign-extended word offset of a branch immediate, already scaled to bytes.
    function automatic logic [WORD_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(WORD_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

    // J-type target: region bits of PC+4 spliced with the 26-bit word index.
    function automatic logic [WORD_W-1:0] jump_target(input logic [3:0]          region,
                                                      input logic [TARGET_W-1:0] target);
        return {region, target, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0]   pc_i,
    input  logic [TARGET_W-1:0] target_i,
    input  logic                branch_i,
    input  logic                zero_i,
    input  logic                jump_i,
    output logic [WORD_W-1:0]   pc_plus4_o,
    output logic [WORD_W-1:0]   pc_next_o
);

    always_comb begin
        pc_plus4_o = pc_i + 32'd4;
        pc_next_o  = pc_plus4_o;
        if (jump_i) begin
            pc_next_o = jump_target(pc_plus4_o[WORD_W-1:WORD_W-4], target_i);
        end else if (branch_i && zero_i) begin
            pc_next_o = pc_plus4_o + branch_offset(target_i[IMM_W-1:0]);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, fetches over a req/ack port, holds the instruction for
// the decode/commit cycle and advances PC once per committed instruction.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              stall_in,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              Jump,
    output logic [WORD_W-1:0] Instr,
    output logic [5:0]        Op,
    output logic [5:0]        Funct,
    output logic              instr_valid,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] PCPlus4,
    output logic [WORD_W-1:0] retire_cnt
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] retire_q, retire_d;
    logic [WORD_W-1:0] pc_next;

    pc_next_logic u_pc_next (
        .pc_i       (pc_q),
        .target_i   (instr_q[TARGET_W-1:0]),
        .branch_i   (Branch),
        .zero_i     (Zero),
        .jump_i     (Jump),
        .pc_plus4_o (PCPlus4),
        .pc_next_o  (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

    // imem_req/instr_valid decode straight from state so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retire_d    = retire_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall_in) begin
                    pc_d     = pc_next;
                    retire_d = retire_q + 32'd1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign Op         = instr_q[OP_MSB:OP_LSB];
    assign Funct      = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed boundary sequence then random traffic.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_in = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall_in    (stall_in),
        .Branch      (Branch),
        .Zero        (Zero),
        .Jump        (Jump),
        .Instr       (Instr),
        .Op          (Op),
        .Funct       (Funct),
        .instr_valid (instr_valid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .retire_cnt  (retire_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } commit_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned commit_total = 0;
    logic [31:0] fetch_q[$];
    commit_t     commit_q[$];
    commit_t     rec;
    logic [31:0] held_instr = '0;
    logic [31:0] model_retire = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Reference next-PC from the architectural rules, plain integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic b, input logic z, input logic j);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(instr[15:0]));
        if (j)
            return (seq & 32'hF000_0000) | (32'(instr[25:0]) * 32'd4);
        if (b && z)
            return seq + 32'(off * 4);
        return seq;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            fetch_q.delete();
            commit_q.delete();
            fetch_q.push_back(32'h0000_0000);
            held_instr   = '0;
            model_retire = '0;
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_pc", PC, 32'h0000_0000);
            chk("rst_instr", Instr, 32'h0);
            chk("rst_retire", retire_cnt, 32'h0);
        end else if (imem_req) begin
            chk("fetch_valid_low", 32'(instr_valid), 32'd0);
            chk("fetch_instr_held", Instr, held_instr);
            if (fetch_q.size() == 0) begin
                fail_now("fetch_addr", "request with no expected fetch address");
            end else begin
                chk("fetch_addr", imem_addr, fetch_q[0]);
                chk("fetch_pc", PC, fetch_q[0]);
                if (imem_ack) begin
                    held_instr = imem_rdata;
                    commit_q.push_back('{pc: fetch_q.pop_front(), instr: imem_rdata});
                end
            end
        end else if (instr_valid) begin
            if (commit_q.size() == 0) begin
                fail_now("commit", "instr_valid with no fetched instruction");
            end else begin
                rec = commit_q[0];
                chk("commit_instr", Instr, rec.instr);
                chk("commit_op", 32'(Op), 32'(rec.instr[31:26]));
                chk("commit_funct", 32'(Funct), 32'(rec.instr[5:0]));
                chk("commit_pc", PC, rec.pc);
                chk("commit_pcplus4", PCPlus4, rec.pc + 32'd4);
                chk("commit_retire", retire_cnt, model_retire);
                if (!stall_in) begin
                    fetch_q.push_back(ref_next(rec.pc, rec.instr, Branch, Zero, Jump));
                    void'(commit_q.pop_front());
                    model_retire = model_retire + 32'd1;
                    commit_total++;
                end
            end
        end else begin
            chk("idle_retire", retire_cnt, model_retire);
            chk("idle_instr", Instr, held_instr);
        end
    end

    task automatic wait_req();
        int unsigned n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) fail_now("wait_req", "imem_req never rose within 20 cycles");
    endtask

    // One instruction: `delay` ack wait cycles, then `stall` stalled commit cycles.
    task automatic run_instr(input logic [31:0] word, input logic b, input logic z, input logic j,
                             input int unsigned delay, input int unsigned stall);
        wait_req();
        for (int unsigned i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            stall_in   = 1'($urandom);
            Branch     = 1'($urandom);
            Zero       = 1'($urandom);
            Jump       = 1'($urandom);
            @(posedge clk); #1;
            chk("ack_wait_req", 32'(imem_req), 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        for (int unsigned i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(instr_valid), 32'd1);
            stall_in   = 1'b1;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            Branch     = 1'($urandom);
            Zero       = 1'($urandom);
            Jump       = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("commit_valid", 32'(instr_valid), 32'd1);
        stall_in = 1'b0;
        imem_ack = 1'b0;
        Branch   = b;
        Zero     = z;
        Jump     = j;
        @(posedge clk); #1;
        chk("post_commit_valid", 32'(instr_valid), 32'd0);
        Branch = 1'b0;
        Zero   = 1'b0;
        Jump   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-latency memory: two cycles per instruction, addresses 0,4,8.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("tim_req", 32'(imem_req), 32'(k % 2));
            chk("tim_valid", 32'(instr_valid), 32'((k % 2 == 0) && (k > 0)));
            if (k % 2 == 1) chk("tim_addr", imem_addr, 32'((k - 1) * 2));
        end
        @(posedge clk); #1;
        imem_ack = 1'b0;

        run_instr(32'h1000_FFFA, 1, 1, 0, 3, 0);
        chk("dir_neg_branch", PC, 32'hFFFF_FFF8);
        run_instr(32'h0800_0010, 1, 1, 1, 0, 0);
        chk("dir_jump_priority", PC, 32'hF000_0040);
        run_instr(32'h0BFF_FFFF, 0, 0, 1, 1, 0);
        chk("dir_jump_region", PC, 32'hFFFF_FFFC);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 4);
        chk("dir_wrap", PC, 32'h0000_0000);
        run_instr(32'h0800_0010, 0, 0, 1, 0, 0);
        chk("dir_jump_40", PC, 32'h0000_0040);
        run_instr(32'h1000_0003, 1, 1, 0, 0, 0);
        chk("dir_beq_taken", PC, 32'h0000_0050);
        run_instr(32'h0800_0010, 0, 0, 1, 2, 0);
        run_instr(32'h1000_0003, 1, 0, 0, 0, 0);
        chk("dir_beq_zero0", PC, 32'h0000_0044);
        run_instr(32'h0800_0010, 0, 0, 1, 0, 0);
        run_instr(32'h1000_FFFF, 1, 1, 0, 0, 1);
        chk("dir_beq_self", PC, 32'h0000_0040);
        run_instr(32'h1000_FFFF, 0, 1, 0, 0, 0);
        chk("dir_branch0", PC, 32'h0000_0044);
        chk("dir_retire", retire_cnt, 32'd14);

        // Reset during a stalled commit: no commit happens.
        wait_req();
        imem_ack = 1'b1;
        imem_rdata = 32'h0800_0020;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        stall_in = 1'b1;
        Jump     = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_stall_valid", 32'(instr_valid), 32'd0);
        chk("rst_stall_retire", retire_cnt, 32'd0);
        chk("rst_stall_pc", PC, 32'h0);
        @(posedge clk); #1;
        stall_in = 1'b0;
        Jump     = 1'b0;
        rst_n    = 1'b1;
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0);
        run_instr(32'h0000_0020, 0, 0, 0, 1, 0);
        chk("post_rst_pc", PC, 32'h0000_0008);

        // Reset while a fetch is outstanding.
        wait_req();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_fetch_req", 32'(imem_req), 32'd0);
        chk("rst_fetch_pc", PC, 32'h0);
        chk("rst_fetch_retire", retire_cnt, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_req();
        chk("refetch_addr", imem_addr, 32'h0);
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0);
        chk("refetch_retire", retire_cnt, 32'd1);

        // Random traffic, checked entirely by the scoreboard.
        commit_total = 0;
        for (int unsigned c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n    = ($urandom % 500) != 0;
            imem_ack = ($urandom % 3) != 0;
            case ($urandom % 4)
                0: imem_rdata = $urandom;
                1: imem_rdata = {6'h04, 10'($urandom), 16'($urandom % 64)};
                2: imem_rdata = {6'h02, 26'($urandom % 4096)};
                default: imem_rdata = {6'h04, 10'($urandom), 16'(16'hFFFF - ($urandom % 64))};
            endcase
            stall_in = ($urandom % 3) == 0;
            Branch   = 1'($urandom);
            Zero     = 1'($urandom);
            Jump     = ($urandom % 4) == 0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        if (commit_total < 200) fail_now("random_progress", "too few commits in random phase");
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
